vram_arbiter: RTL and testbench

- Shares one single-port synchronous video RAM (the 40x30 text/attribute store) between three requesters: VGA scanout (read-only), CPU16 data bus (read/write) and SPI debug bridge (read/write).
- Sits inside system_cpu16_vga40x30, between the RAM macro and the vga, cpu16 and spi_debug blocks.
- VGA has absolute priority and fixed latency. CPU and SPI share the remaining cycles round-robin.

---
 rtl/vram_pkg.sv | 21 ++
 rtl/vram_arbiter_if.sv | 63 ++++++
 rtl/rr_arb2.sv | 34 +++
 rtl/vram_arbiter.sv | 120 ++++++++++++
 tb/tb_vram_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_pkg.sv
// Shared constants for the video RAM arbiter slice.
// Read-owner encoding and default bus widths.
package vram_pkg;

    localparam int AW_DEF = 11;
    localparam int DW_DEF = 16;
    localparam int SW_DEF = 16;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_VGA  = 2'd1;
    localparam logic [1:0] OWN_CPU  = 2'd2;
    localparam logic [1:0] OWN_SPI  = 2'd3;

    typedef enum logic [1:0] {
        O_NONE = OWN_NONE,
        O_VGA  = OWN_VGA,
        O_CPU  = OWN_CPU,
        O_SPI  = OWN_SPI
    } owner_e;

endpackage

// File: rtl/vram_arbiter_if.sv
// Bus bundle between VGA/CPU/SPI clients, the RAM macro and the arbiter.
// slave: arbiter side. master: clients + RAM side.
interface vram_arbiter_if
    import vram_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int SW = SW_DEF
);
    logic          vga_req;
    logic [AW-1:0] vga_addr;
    logic [DW-1:0] vga_rdata;
    logic          vga_rvalid;

    logic          cpu_valid;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ready;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_rvalid;

    logic          spi_valid;
    logic          spi_we;
    logic [AW-1:0] spi_addr;
    logic [DW-1:0] spi_wdata;
    logic          spi_ready;
    logic [DW-1:0] spi_rdata;
    logic          spi_rvalid;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_re;
    logic [DW-1:0] mem_rdata;

    logic [SW-1:0] stall_cnt;

    modport slave (
        input  vga_req, vga_addr,
        output vga_rdata, vga_rvalid,
        input  cpu_valid, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ready, cpu_rdata, cpu_rvalid,
        input  spi_valid, spi_we, spi_addr, spi_wdata,
        output spi_ready, spi_rdata, spi_rvalid,
        output mem_addr, mem_wdata, mem_we, mem_re,
        input  mem_rdata,
        output stall_cnt
    );

    modport master (
        output vga_req, vga_addr,
        input  vga_rdata, vga_rvalid,
        output cpu_valid, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ready, cpu_rdata, cpu_rvalid,
        output spi_valid, spi_we, spi_addr, spi_wdata,
        input  spi_ready, spi_rdata, spi_rvalid,
        input  mem_addr, mem_wdata, mem_we, mem_re,
        output mem_rdata,
        input  stall_cnt
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; pointer moves only on contention.
// Ports: clk, rst_n, req_i[1:0] (0=CPU,1=SPI), gnt_o[1:0] one-hot.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    // 1 = SPI served last, so CPU wins the next tie.
    logic last_q;
    logic last_d;
    logic [1:0] gnt;

    always_comb begin
        gnt[0] = req_i[0] & (~req_i[1] | last_q);
        gnt[1] = req_i[1] & (~req_i[0] | ~last_q);
        last_d = last_q;
        if (&req_i) begin
            last_d = gnt[1];
        end
    end

    assign gnt_o = gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: VGA absolute priority, CPU/SPI round-robin.
// Ports: clk, rst_n, bus (vram_arbiter_if.slave: clients, RAM, stall_cnt).
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int SW = SW_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    vram_arbiter_if.slave  bus
);

    owner_e        owner_q;
    owner_e        owner_d;
    logic [SW-1:0] stall_q;
    logic [SW-1:0] stall_d;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] wdata_d;

    logic          vga_g;
    logic [1:0]    req;
    logic [1:0]    gnt;
    logic          cpu_rdy;
    logic          spi_rdy;
    logic          m_we;
    logic          m_re;
    logic          stall_inc;

    // VGA steals the slot before the round-robin sees any request.
    assign vga_g = rst_n & bus.vga_req;
    assign req   = {bus.spi_valid, bus.cpu_valid}
                 & {2{rst_n & ~bus.vga_req}};

    rr_arb2 u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (req),
        .gnt_o (gnt)
    );

    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        m_we    = 1'b0;
        m_re    = 1'b0;
        cpu_rdy = 1'b0;
        spi_rdy = 1'b0;
        owner_d = O_NONE;
        unique case (1'b1)
            vga_g: begin
                addr_d  = bus.vga_addr;
                m_re    = 1'b1;
                owner_d = O_VGA;
            end
            gnt[0]: begin
                addr_d  = bus.cpu_addr;
                wdata_d = bus.cpu_wdata;
                m_we    = bus.cpu_we;
                m_re    = ~bus.cpu_we;
                cpu_rdy = 1'b1;
                owner_d = bus.cpu_we ? O_NONE : O_CPU;
            end
            gnt[1]: begin
                addr_d  = bus.spi_addr;
                wdata_d = bus.spi_wdata;
                m_we    = bus.spi_we;
                m_re    = ~bus.spi_we;
                spi_rdy = 1'b1;
                owner_d = bus.spi_we ? O_NONE : O_SPI;
            end
            default: begin
            end
        endcase
    end

    // Idle cycles hold the last address/data on the RAM pins.
    assign bus.mem_addr  = addr_d;
    assign bus.mem_wdata = wdata_d;
    assign bus.mem_we    = m_we;
    assign bus.mem_re    = m_re;
    assign bus.cpu_ready = cpu_rdy;
    assign bus.spi_ready = spi_rdy;

    assign stall_inc = (bus.cpu_valid & ~cpu_rdy)
                     | (bus.spi_valid & ~spi_rdy);

    always_comb begin
        stall_d = stall_q;
        if (stall_inc && !(&stall_q)) begin
            stall_d = stall_q + {{(SW-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= O_NONE;
            stall_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            owner_q <= owner_d;
            stall_q <= stall_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.vga_rvalid = (owner_q == O_VGA);
    assign bus.cpu_rvalid = (owner_q == O_CPU);
    assign bus.spi_rvalid = (owner_q == O_SPI);
    assign bus.vga_rdata  = bus.mem_rdata;
    assign bus.cpu_rdata  = bus.mem_rdata;
    assign bus.spi_rdata  = bus.mem_rdata;
    assign bus.stall_cnt  = stall_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural sync RAM.
// Built with SW=4 so stall saturation is reachable quickly.
module tb_vram_arbiter;

    localparam int AW = 11;
    localparam int DW = 16;
    localparam int SW = 4;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] rdq;

    vram_arbiter_if #(.AW(AW), .DW(DW), .SW(SW)) bus ();

    vram_arbiter #(.AW(AW), .DW(DW), .SW(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re) rdq <= ram[bus.mem_addr];
    end
    assign bus.mem_rdata = rdq;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.vga_req   = 1'b0;
        bus.vga_addr  = '0;
        bus.cpu_valid = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.spi_valid = 1'b0;
        bus.spi_we    = 1'b0;
        bus.spi_addr  = '0;
        bus.spi_wdata = '0;
    endtask

    task automatic do_reset();
        step();
        idle();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        step();
        rst_n = 1'b0;
        bus.vga_req   = 1'b1;
        bus.vga_addr  = 11'h010;
        bus.cpu_valid = 1'b1;
        bus.spi_valid = 1'b1;
        step();
        n_tests++;
        if (bus.mem_re !== 1'b0 || bus.mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mem re=%b we=%b want 0/0",
                     bus.mem_re, bus.mem_we);
        end
        n_tests++;
        if (bus.cpu_ready !== 1'b0 || bus.spi_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready cpu=%b spi=%b want 0/0",
                     bus.cpu_ready, bus.spi_ready);
        end
        n_tests++;
        if ({bus.vga_rvalid, bus.cpu_rvalid, bus.spi_rvalid} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_rvalid got %b%b%b want 000",
                     bus.vga_rvalid, bus.cpu_rvalid, bus.spi_rvalid);
        end
        n_tests++;
        if (bus.stall_cnt !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_stall got %h want 0", bus.stall_cnt);
        end
        idle();
        rst_n = 1'b1;
    endtask

    task automatic test_cpu_read();
        do_reset();
        bus.cpu_valid = 1'b1;
        bus.cpu_addr  = 11'h005;
        #1;
        n_tests++;
        if (bus.cpu_ready !== 1'b1 || bus.mem_re !== 1'b1
            || bus.mem_addr !== 11'h005) begin
            n_fail++;
            $display("FAIL cpu_rd_grant rdy=%b re=%b addr=%h want 1/1/005",
                     bus.cpu_ready, bus.mem_re, bus.mem_addr);
        end
        step();
        bus.cpu_valid = 1'b0;
        n_tests++;
        if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 16'h1234) begin
            n_fail++;
            $display("FAIL cpu_rd_data rv=%b data=%h want 1/1234",
                     bus.cpu_rvalid, bus.cpu_rdata);
        end
        n_tests++;
        if (bus.stall_cnt !== 4'h0) begin
            n_fail++;
            $display("FAIL cpu_rd_stall got %h want 0", bus.stall_cnt);
        end
        step();
        n_tests++;
        if (bus.cpu_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL cpu_rd_pulse rv=%b want 0", bus.cpu_rvalid);
        end
    endtask

    task automatic test_vga_priority();
        do_reset();
        bus.cpu_valid = 1'b1;
        bus.cpu_addr  = 11'h005;
        bus.vga_req   = 1'b1;
        bus.vga_addr  = 11'h010;
        #1;
        n_tests++;
        if (bus.cpu_ready !== 1'b0 || bus.mem_addr !== 11'h010
            || bus.mem_re !== 1'b1) begin
            n_fail++;
            $display("FAIL vga_pri_grant crdy=%b addr=%h re=%b want 0/010/1",
                     bus.cpu_ready, bus.mem_addr, bus.mem_re);
        end
        step();
        bus.vga_req = 1'b0;
        #1;
        n_tests++;
        if (bus.vga_rvalid !== 1'b1 || bus.vga_rdata !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL vga_pri_data rv=%b data=%h want 1/beef",
                     bus.vga_rvalid, bus.vga_rdata);
        end
        n_tests++;
        if (bus.cpu_ready !== 1'b1 || bus.stall_cnt !== 4'h1) begin
            n_fail++;
            $display("FAIL vga_pri_cpu rdy=%b stall=%h want 1/1",
                     bus.cpu_ready, bus.stall_cnt);
        end
        step();
        bus.cpu_valid = 1'b0;
        n_tests++;
        if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 16'h1234
            || bus.stall_cnt !== 4'h1) begin
            n_fail++;
            $display("FAIL vga_pri_cpu_data rv=%b data=%h stall=%h",
                     bus.cpu_rvalid, bus.cpu_rdata, bus.stall_cnt);
        end
    endtask

    task automatic test_round_robin();
        logic prev_cpu;
        do_reset();
        bus.cpu_valid = 1'b1;
        bus.cpu_addr  = 11'h020;
        bus.spi_valid = 1'b1;
        bus.spi_addr  = 11'h030;
        prev_cpu = 1'b0;
        for (int k = 0; k < 6; k++) begin
            logic want_cpu;
            want_cpu = (k % 2) == 0;
            #1;
            n_tests++;
            if (bus.cpu_ready !== want_cpu || bus.spi_ready !== !want_cpu) begin
                n_fail++;
                $display("FAIL rr_grant%0d cpu=%b spi=%b want %b/%b", k,
                         bus.cpu_ready, bus.spi_ready, want_cpu, !want_cpu);
            end
            if (k > 0) begin
                n_tests++;
                if (bus.cpu_rvalid !== prev_cpu
                    || bus.spi_rvalid !== !prev_cpu
                    || bus.cpu_rdata !== (prev_cpu ? 16'h1111 : 16'h2222)) begin
                    n_fail++;
                    $display("FAIL rr_ret%0d crv=%b srv=%b data=%h", k,
                             bus.cpu_rvalid, bus.spi_rvalid, bus.cpu_rdata);
                end
            end
            prev_cpu = want_cpu;
            step();
        end
        bus.cpu_valid = 1'b0;
        bus.spi_valid = 1'b0;
        n_tests++;
        if (bus.spi_rvalid !== 1'b1 || bus.spi_rdata !== 16'h2222
            || bus.cpu_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_last srv=%b data=%h crv=%b want 1/2222/0",
                     bus.spi_rvalid, bus.spi_rdata, bus.cpu_rvalid);
        end
        n_tests++;
        if (bus.stall_cnt !== 4'h6) begin
            n_fail++;
            $display("FAIL rr_stall got %h want 6", bus.stall_cnt);
        end
    endtask

    task automatic test_write_then_read();
        do_reset();
        bus.spi_valid = 1'b1;
        bus.spi_we    = 1'b1;
        bus.spi_addr  = 11'h4AF;
        bus.spi_wdata = 16'hA5A5;
        #1;
        n_tests++;
        if (bus.spi_ready !== 1'b1 || bus.mem_we !== 1'b1
            || bus.mem_re !== 1'b0 || bus.mem_wdata !== 16'hA5A5) begin
            n_fail++;
            $display("FAIL wr_grant rdy=%b we=%b re=%b wd=%h",
                     bus.spi_ready, bus.mem_we, bus.mem_re, bus.mem_wdata);
        end
        step();
        bus.spi_valid = 1'b0;
        bus.spi_we    = 1'b0;
        bus.cpu_valid = 1'b1;
        bus.cpu_addr  = 11'h4AF;
        #1;
        n_tests++;
        if (bus.spi_rvalid !== 1'b0 || bus.cpu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_no_rvalid srv=%b crdy=%b want 0/1",
                     bus.spi_rvalid, bus.cpu_ready);
        end
        step();
        bus.cpu_valid = 1'b0;
        n_tests++;
        if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 16'hA5A5) begin
            n_fail++;
            $display("FAIL raw_data rv=%b data=%h want 1/a5a5",
                     bus.cpu_rvalid, bus.cpu_rdata);
        end
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        bus.cpu_valid = 1'b1;
        bus.cpu_addr  = 11'h005;
        bus.spi_valid = 1'b1;
        bus.spi_addr  = 11'h030;
        step();
        bus.spi_valid = 1'b0;
        #1;
        n_tests++;
        if (bus.cpu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_grant rdy=%b want 1", bus.cpu_ready);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.cpu_ready !== 1'b0 || bus.mem_re !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_gated rdy=%b re=%b want 0/0",
                     bus.cpu_ready, bus.mem_re);
        end
        bus.cpu_valid = 1'b0;
        #1;
        rst_n = 1'b1;
        step();
        n_tests++;
        if (bus.cpu_rvalid !== 1'b0 || bus.stall_cnt !== 4'h0) begin
            n_fail++;
            $display("FAIL mid_drop rv=%b stall=%h want 0/0",
                     bus.cpu_rvalid, bus.stall_cnt);
        end
        bus.cpu_valid = 1'b1;
        bus.spi_valid = 1'b1;
        #1;
        n_tests++;
        if (bus.cpu_ready !== 1'b1 || bus.spi_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_ptr cpu=%b spi=%b want 1/0",
                     bus.cpu_ready, bus.spi_ready);
        end
        idle();
    endtask

    task automatic test_stall_saturate();
        do_reset();
        bus.vga_req   = 1'b1;
        bus.vga_addr  = 11'h010;
        bus.cpu_valid = 1'b1;
        bus.cpu_addr  = 11'h005;
        for (int i = 0; i < (1 << SW) + 3; i++) begin
            int want;
            step();
            want = (i + 1 > 15) ? 15 : i + 1;
            n_tests++;
            if (bus.stall_cnt !== want[SW-1:0] || bus.cpu_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL sat%0d stall=%h rdy=%b want %h/0", i,
                         bus.stall_cnt, bus.cpu_ready, want[SW-1:0]);
            end
        end
        idle();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        idle();
        for (int a = 0; a < (1 << AW); a++) ram[a] = '0;
        ram[11'h005] = 16'h1234;
        ram[11'h010] = 16'hBEEF;
        ram[11'h020] = 16'h1111;
        ram[11'h030] = 16'h2222;
        rdq = '0;
        test_reset();
        test_cpu_read();
        test_vga_priority();
        test_round_robin();
        test_write_then_read();
        test_reset_mid_read();
        test_stall_saturate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
